// File: rtl/soc_msp430_noc_out_arbiter.sv
// soc_msp430_noc_out_arbiter: packet-level round-robin arbiter that shares
// one outbound NoC channel between PORTS local flit sources.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   in_flit/last    per-requester flit and end-of-packet marker
//   in_valid/ready  per-requester handshake (ready only to the locked port)
//   out_flit/last   registered flit and end-of-packet marker to the NoC
//   out_valid/ready registered handshake toward the NoC channel
//   busy            high while a packet is being forwarded
//   grant_id        index of the current (or last) granted requester
//
// Build option: define SOC_MSP430_NOC_ARB_FIXED_PRIO_EN to pin the search
// start at port 0, so the lowest-index requester always wins.
module soc_msp430_noc_out_arbiter #(
  parameter  int FLIT_WIDTH = 32,
  parameter  int PORTS      = 2,
  localparam int IDW        = $clog2(PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [PORTS-1:0]                 in_last,
  input  logic [PORTS-1:0]                 in_valid,
  output logic [PORTS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic [IDW-1:0]                   grant_id
);

  localparam int IW1 = IDW + 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic [IW1-1:0] idx;
  logic           can_load;
  logic           xfer;

  // One spare bit so rr_ptr + k never overflows before the explicit wrap;
  // subtracting PORTS keeps non-power-of-2 port counts in range.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = {1'b0, rr_ptr} + IW1'(k);
      if (idx >= IW1'(PORTS)) begin
        idx = idx - IW1'(PORTS);
      end
      if (!found && in_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  // Ready never looks at in_valid: only at lock state and output slot.
  assign can_load = (state == LOCKED) &&
                    (!out_valid || out_ready);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < PORTS; i++) begin
      in_ready[i] = can_load && (grant_id == IDW'(i));
    end
  end

  assign xfer = can_load && in_valid[grant_id];
  assign busy = (state == LOCKED);

`ifndef SOC_MSP430_NOC_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] nxt_ptr;

  assign nxt_ptr = (grant_id == IDW'(PORTS - 1)) ?
                   '0 : grant_id + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      out_flit  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id <= win;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && in_last[grant_id]) begin
            state <= IDLE;
`ifdef SOC_MSP430_NOC_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= nxt_ptr;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Load wins over drain, so back-to-back flits keep out_valid high.
      if (xfer) begin
        out_flit  <= in_flit[grant_id];
        out_last  <= in_last[grant_id];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
